// File: rtl/compare_arbiter_pkg.sv
// Shared definitions for the compare arbiter: op codes, FSM states,
// comparator result bit positions and the op-to-result decode.
package compare_arbiter_pkg;

    localparam logic [2:0] OP_SLTU = 3'd0;
    localparam logic [2:0] OP_SLT  = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_NE   = 3'd3;
    localparam logic [2:0] OP_LTU  = 3'd4;
    localparam logic [2:0] OP_GEU  = 3'd5;
    localparam logic [2:0] OP_LT   = 3'd6;
    localparam logic [2:0] OP_GE   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CMP_LT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 0;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_SLT) || (op == OP_LT) || (op == OP_GE);
    endfunction

    // "Greater or equal" is formed as eq|gt, which is the same as !lt.
    function automatic logic op_result(input logic [2:0] op, input logic [2:0] cmp);
        logic r;
        case (op)
            OP_SLTU, OP_SLT, OP_LTU, OP_LT: r = cmp[CMP_LT];
            OP_EQ:                          r = cmp[CMP_EQ];
            OP_NE:                          r = ~cmp[CMP_EQ];
            OP_GEU, OP_GE:                  r = cmp[CMP_EQ] | cmp[CMP_GT];
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator producing the {lt,eq,gt} result vector.
module comparator
    import compare_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       res
);

    // Pure combinational compare of the two operands.
    always_comb begin
        res         = 3'b000;
        res[CMP_LT] = (a < b);
        res[CMP_EQ] = (a == b);
        res[CMP_GT] = (a > b);
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first valid requester at or after ptr, wrapping,
// returned both one-hot and as an index.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    localparam int SW = IDW + 1;
    localparam logic [SW-1:0] N_S = SW'(NUM_REQ);

    // Scan requesters in priority order starting at ptr.
    always_comb begin
        logic          found;
        logic          hit;
        logic [SW-1:0] sum;
        logic [IDW-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        hit      = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum        = {1'b0, ptr} + SW'(i);
            idx        = (sum >= N_S) ? IDW'(sum - N_S) : IDW'(sum);
            hit        = ~found & valid[idx];
            grant[idx] = grant[idx] | hit;
            grant_id   = hit ? idx : grant_id;
            found      = found | hit;
        end
    end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin shared comparator: accept a request in IDLE, compare in COMP,
// hold the 0/1 result in RESP until the owning requester accepts it.
module compare_arbiter
    import compare_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                       iClk,
    input  logic                       iRstN,
    input  logic [NUM_REQ-1:0]         iReqValid,
    output logic [NUM_REQ-1:0]         oReqReady,
    input  logic [3*NUM_REQ-1:0]       iOp,
    input  logic [WIDTH*NUM_REQ-1:0]   iDataA,
    input  logic [WIDTH*NUM_REQ-1:0]   iDataB,
    output logic [NUM_REQ-1:0]         oRspValid,
    input  logic [NUM_REQ-1:0]         iRspReady,
    output logic [WIDTH-1:0]           oRspData,
    output logic                       oBusy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH-1:0]   SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]     LAST_ID   = IDW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   pick_grant_s;
    logic [IDW-1:0]       pick_id_s;
    logic [WIDTH-1:0]     cmp_a_s, cmp_b_s;
    logic [2:0]           cmp_res_s;
    logic [2:0]           op_arr_s [NUM_REQ];
    logic [WIDTH-1:0]     a_arr_s  [NUM_REQ];
    logic [WIDTH-1:0]     b_arr_s  [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign op_arr_s[k] = iOp[3*k +: 3];
        assign a_arr_s[k]  = iDataA[WIDTH*k +: WIDTH];
        assign b_arr_s[k]  = iDataB[WIDTH*k +: WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_picker (
        .valid    (iReqValid),
        .ptr      (rr_ptr_q),
        .grant    (pick_grant_s),
        .grant_id (pick_id_s)
    );

    // Grant is only offered in IDLE and never while reset is asserted.
    assign oReqReady = (iRstN && (state_q == IDLE)) ? pick_grant_s : '0;

    // Signed compares become unsigned by flipping the sign bit of both operands.
    always_comb begin
        if (op_is_signed(op_q)) begin
            cmp_a_s = a_q ^ SIGN_MASK;
            cmp_b_s = b_q ^ SIGN_MASK;
        end else begin
            cmp_a_s = a_q;
            cmp_b_s = b_q;
        end
    end

    comparator #(
        .WIDTH (WIDTH)
    ) u_comparator (
        .a   (cmp_a_s),
        .b   (cmp_b_s),
        .res (cmp_res_s)
    );

    // Next-state and datapath decisions for the IDLE/COMP/RESP sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (|(iReqValid & oReqReady)) begin
                    grant_id_d = pick_id_s;
                    op_d       = op_arr_s[pick_id_s];
                    a_d        = a_arr_s[pick_id_s];
                    b_d        = b_arr_s[pick_id_s];
                    busy_d     = 1'b1;
                    state_d    = COMP;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            COMP: begin
                rsp_data_d  = {{(WIDTH-1){1'b0}}, op_result(op_q, cmp_res_s)};
                rsp_valid_d = ONE_HOT0 << grant_id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (iRspReady[grant_id_q]) begin
                    rsp_valid_d = '0;
                    rsp_data_d  = '0;
                    busy_d      = 1'b0;
                    rr_ptr_d    = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = '0;
                rsp_data_d  = '0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign oRspValid = rsp_valid_q;
    assign oRspData  = rsp_data_q;
    assign oBusy     = busy_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed self-checking bench for compare_arbiter (NUM_REQ=2, WIDTH=32);
// inputs change and outputs are sampled around the falling clock edge.
module tb_compare_arbiter;

    localparam logic [2:0] OP_SLTU = 3'd0;
    localparam logic [2:0] OP_SLT  = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_NE   = 3'd3;
    localparam logic [2:0] OP_LTU  = 3'd4;
    localparam logic [2:0] OP_GEU  = 3'd5;
    localparam logic [2:0] OP_GE   = 3'd7;

    logic        iClk;
    logic        iRstN;
    logic [1:0]  iReqValid;
    logic [1:0]  oReqReady;
    logic [5:0]  iOp;
    logic [63:0] iDataA;
    logic [63:0] iDataB;
    logic [1:0]  oRspValid;
    logic [1:0]  iRspReady;
    logic [31:0] oRspData;
    logic        oBusy;

    int n_assert = 0;
    int n_fail   = 0;

    compare_arbiter #(
        .NUM_REQ (2),
        .WIDTH   (32)
    ) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iReqValid (iReqValid),
        .oReqReady (oReqReady),
        .iOp       (iOp),
        .iDataA    (iDataA),
        .iDataB    (iDataB),
        .oRspValid (oRspValid),
        .iRspReady (iRspReady),
        .oRspData  (oRspData),
        .oBusy     (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        iOp[3*r +: 3]     = op;
        iDataA[32*r +: 32] = a;
        iDataB[32*r +: 32] = b;
    endtask

    // One isolated request from requester r; starts and ends at a falling edge in IDLE.
    task automatic single(input int r, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << r;
        load(r, op, a, b);
        iReqValid[r] = 1'b1;
        #1;
        chk({tag, " req_ready"}, 32'(oReqReady), 32'(oh));
        @(negedge iClk);
        iReqValid[r] = 1'b0;
        @(negedge iClk);
        chk({tag, " rsp_valid"}, 32'(oRspValid), 32'(oh));
        chk({tag, " rsp_data"}, oRspData, exp);
        iRspReady = oh;
        @(negedge iClk);
        iRspReady = 2'b00;
        chk({tag, " rsp_valid_clear"}, 32'(oRspValid), 32'd0);
    endtask

    initial begin
        logic [1:0] oh;
        iRstN     = 1'b0;
        iReqValid = 2'b11;
        iRspReady = 2'b00;
        iOp       = 6'd0;
        iDataA    = 64'd0;
        iDataB    = 64'd0;
        @(negedge iClk);
        @(negedge iClk);
        chk("reset req_ready", 32'(oReqReady), 32'd0);
        chk("reset rsp_valid", 32'(oRspValid), 32'd0);
        chk("reset rsp_data", oRspData, 32'd0);
        chk("reset busy", 32'(oBusy), 32'd0);
        iReqValid = 2'b00;
        iRstN     = 1'b1;
        @(negedge iClk);

        // SLTU 5<9 from requester 0 with 3 cycles of response back-pressure.
        load(0, OP_SLTU, 32'h0000_0005, 32'h0000_0009);
        iReqValid = 2'b01;
        #1;
        chk("sltu req_ready", 32'(oReqReady), 32'd1);
        @(negedge iClk);
        iReqValid = 2'b00;
        chk("sltu comp busy", 32'(oBusy), 32'd1);
        chk("sltu comp rsp_valid", 32'(oRspValid), 32'd0);
        chk("sltu comp rsp_data", oRspData, 32'd0);
        @(negedge iClk);
        for (int i = 0; i < 3; i++) begin
            chk("sltu hold rsp_valid", 32'(oRspValid), 32'd1);
            chk("sltu hold rsp_data", oRspData, 32'd1);
            @(negedge iClk);
        end
        iRspReady = 2'b01;
        @(negedge iClk);
        iRspReady = 2'b00;
        chk("sltu done rsp_valid", 32'(oRspValid), 32'd0);
        chk("sltu done rsp_data", oRspData, 32'd0);
        chk("sltu done busy", 32'(oBusy), 32'd0);

        // Signed vs unsigned with A=-1, B=1; requesters chosen so the pointer ends at 0.
        single(1, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1, "slt");
        single(0, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, "sltu_neg");
        single(1, OP_GE,   32'hFFFF_FFFF, 32'h0000_0001, 32'd0, "ge");
        single(0, OP_GEU,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1, "geu");
        single(0, OP_EQ,   32'h8000_0000, 32'h8000_0000, 32'd1, "eq");
        single(1, OP_NE,   32'h8000_0000, 32'h8000_0000, 32'd0, "ne");

        // Contention: both requesters held valid, grants alternate 0,1,0,1.
        load(0, OP_LTU, 32'd3, 32'd7);
        load(1, OP_GEU, 32'd3, 32'd7);
        iReqValid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            oh = 2'b01 << (g % 2);
            #1;
            chk("cont req_ready", 32'(oReqReady), 32'(oh));
            @(negedge iClk);
            @(negedge iClk);
            chk("cont rsp_valid", 32'(oRspValid), 32'(oh));
            chk("cont rsp_data", oRspData, (g % 2 == 0) ? 32'd1 : 32'd0);
            iRspReady = ~oh;
            @(negedge iClk);
            chk("cont non_owner_ready_ignored", 32'(oRspValid), 32'(oh));
            chk("cont non_owner busy", 32'(oBusy), 32'd1);
            iRspReady = oh;
            @(negedge iClk);
            iRspReady = 2'b00;
            if (g == 3) iReqValid = 2'b00;
        end

        // Back-pressure: requester 1 waits while requester 0's response is pending.
        load(0, OP_EQ, 32'd1, 32'd1);
        load(1, OP_SLTU, 32'd1, 32'd2);
        iReqValid = 2'b01;
        #1;
        chk("bp req0 ready", 32'(oReqReady), 32'd1);
        @(negedge iClk);
        iReqValid = 2'b10;
        #1;
        chk("bp comp ready", 32'(oReqReady), 32'd0);
        @(negedge iClk);
        chk("bp resp ready", 32'(oReqReady), 32'd0);
        chk("bp resp rsp_valid", 32'(oRspValid), 32'd1);
        chk("bp resp rsp_data", oRspData, 32'd1);
        @(negedge iClk);
        chk("bp resp hold ready", 32'(oReqReady), 32'd0);
        iRspReady = 2'b01;
        @(negedge iClk);
        iRspReady = 2'b00;
        #1;
        chk("bp req1 ready", 32'(oReqReady), 32'd2);
        @(negedge iClk);
        iReqValid = 2'b00;
        @(negedge iClk);
        chk("bp req1 rsp_valid", 32'(oRspValid), 32'd2);
        chk("bp req1 rsp_data", oRspData, 32'd1);
        iRspReady = 2'b10;
        @(negedge iClk);
        iRspReady = 2'b00;

        // Reset during COMP; pointer is moved to 1 first so its reset is visible.
        single(0, OP_EQ, 32'd5, 32'd5, 32'd1, "pre_rst");
        load(1, OP_NE, 32'd5, 32'd6);
        iReqValid = 2'b10;
        #1;
        chk("rst req1 ready", 32'(oReqReady), 32'd2);
        @(negedge iClk);
        iReqValid = 2'b00;
        iRstN = 1'b0;
        @(negedge iClk);
        chk("rst busy", 32'(oBusy), 32'd0);
        chk("rst rsp_valid", 32'(oRspValid), 32'd0);
        chk("rst rsp_data", oRspData, 32'd0);
        iRstN = 1'b1;
        @(negedge iClk);
        chk("post_rst rsp_valid a", 32'(oRspValid), 32'd0);
        @(negedge iClk);
        chk("post_rst rsp_valid b", 32'(oRspValid), 32'd0);
        chk("post_rst busy", 32'(oBusy), 32'd0);
        iReqValid = 2'b11;
        #1;
        chk("post_rst ptr0 wins", 32'(oReqReady), 32'd1);
        @(negedge iClk);
        iReqValid = 2'b00;
        @(negedge iClk);
        chk("post_rst rsp_valid", 32'(oRspValid), 32'd1);
        chk("post_rst rsp_data", oRspData, 32'd1);
        iRspReady = 2'b01;
        @(negedge iClk);
        iRspReady = 2'b00;
        chk("post_rst done", 32'(oRspValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Shares one `comparator` instance (unsigned, 3-bit `{lt,eq,gt}` result) between NUM_REQ requesters, e.g. the ALU set-less-than path and the branch unit.
- Round-robin arbitration with valid/ready handshakes on both the request and the response side.
- Signed compares are done by flipping operand bit 31 before the comparator.
- Multi-cycle: operands registered, compared, then the result is held until accepted.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- WIDTH, 32, operand and result width.

Ports:
- iClk  input  1  clock.
- iRstN  input  1  synchronous active-low reset.
- iReqValid  input  NUM_REQ  per-requester request valid.
- oReqReady  output  NUM_REQ  per-requester request accept; one-hot or zero.
- iOp  input  3*NUM_REQ  per-requester op code; requester k uses bits [3k+2:3k].
- iDataA  input  WIDTH*NUM_REQ  per-requester operand A; slice k.
- iDataB  input  WIDTH*NUM_REQ  per-requester operand B; slice k.
- oRspValid  output  NUM_REQ  one-hot response valid to the owning requester.
- iRspReady  input  NUM_REQ  per-requester response accept.
- oRspData  output  WIDTH  result, 0 or 1 zero-extended, shared by all requesters.
- oBusy  output  1  high in any state other than IDLE.

Behaviour:
- Op codes:
  - 0 SLTU, 1 SLT, 2 EQ, 3 NE, 4 LTU, 5 GEU, 6 LT, 7 GE.
  - Signed ops (SLT, LT, GE) XOR bit WIDTH-1 of both operands before the comparator.
  - Result bit 0:
    - SLTU/SLT/LTU/LT = lt
    - EQ = eq
    - NE = !eq
    - GEU/GE = !lt
  - All other result bits are 0.
- FSM states: IDLE, COMP, RESP.
  - IDLE:
    - Grant goes to the first valid requester at or after rrPtr, in wrapping order.
    - oReqReady[grant] is asserted combinationally, the same cycle, only when some iReqValid is high.
    - On handshake: latch op, A, B and grant id; go to COMP.
  - COMP:
    - Comparator sees the registered operands.
    - Result is registered into rspData; go to RESP.
    - oReqReady stays all-zero.
  - RESP:
    - oRspValid[grantId] = 1 and oRspData = rspData, both stable until the handshake.
    - On iRspReady[grantId]: go to IDLE and set rrPtr = grantId+1, wrapping at NUM_REQ.
    - iRspReady from any other requester is ignored.
- Latency: request accepted in cycle N, response valid in cycle N+2. Minimum occupancy is 3 cycles per request.
- Fairness: a requester that keeps iReqValid high waits at most NUM_REQ-1 other grants.
- A request withdrawn before its handshake is never granted; there is no partial state.
- The grant decision is evaluated only in IDLE. Requests arriving in COMP or RESP wait.
- Reset:
  - Reset values: state=IDLE, rrPtr=0, oReqReady=0, oRspValid=0, oRspData=0, oBusy=0.
  - Reset asserted mid-operation discards the in-flight request; no response is issued.
- oRspData is 0 whenever oRspValid is all-zero.

Decomposition:
- Shared package holds:
  - op-code localparams (OP_SLTU..OP_GE)
  - state encoding (IDLE/COMP/RESP)
  - comparator result bit indices (LT=2, EQ=1, GT=0)
- Existing sub-module `comparator` is instantiated once.
- The round-robin picker is a natural sub-module, rr_picker (NUM_REQ-wide: valid + pointer -> one-hot grant).

Test Plan:
- SLTU from requester 0, A=32'h0000_0005, B=32'h0000_0009:
  - oReqReady=2'b01 the same cycle
  - oRspValid=2'b01 two cycles later, oRspData=1
  - hold iRspReady=0 for 3 cycles: data and valid must stay stable.
- Signed compares, A=32'hFFFF_FFFF, B=32'h0000_0001:
  - SLT -> 1
  - SLTU -> 0
  - GE -> 0
  - GEU -> 1
- EQ/NE, A=B=32'h8000_0000: EQ -> 1, NE -> 0.
- Contention with both iReqValid held high for 4 requests:
  - grants alternate 0,1,0,1
  - each oRspValid goes only to its owner
  - iRspReady from the non-owner does not complete the transaction.
- Back-pressure: requester 1 posts while requester 0's response sits unaccepted in RESP -> oReqReady stays 0 until requester 0 accepts, then requester 1 is granted in IDLE.
- Reset mid-operation: drive iRstN=0 in COMP -> next cycle oBusy=0 and oRspValid=0, no response ever appears; rrPtr=0, so requester 0 wins the next contention.
